uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE      = 16;
    localparam int MID_TICK        = 7;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments so both flops sample on the same edge and form a true 2-stage pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver; framing-error output enabled by UART_RX_FRAMING_ERR_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    output logic            framing_err
`endif
);

    // Tick counter must reach both the data-bit length and a long stop bit.
    localparam int S_W = ($clog2(SB_TICK) > $clog2(OVERSAMPLE)) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    rx_state_t       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a hold-value default first so no path through the case infers a latch.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = '0;
                        b_d = DBIT'({rx_s, b_q} >> 1);
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_done_tick = 1'b0;
`ifdef UART_RX_FRAMING_ERR_EN
        framing_err  = 1'b0;
`endif
        if (!reset && state_q == STOP && s_tick && s_q == S_STOP) begin
            rx_done_tick = 1'b1;
`ifdef UART_RX_FRAMING_ERR_EN
            framing_err  = !rx_s;
`endif
        end
    end

    assign dout = b_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, scoreboard queue, and hand-written corner cases.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        bit         stop_low;
        int         gap;
        logic [7:0] exp_dout;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx32;
    logic       s_tick;
    logic [7:0] dout;
    logic [7:0] dout32;
    logic       rx_done_tick;
    logic       done32;
`ifdef UART_RX_FRAMING_ERR_EN
    logic       framing_err;
    logic       ferr32;
`endif

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   pulses     = 0;
    int   pushes     = 0;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick)
`ifdef UART_RX_FRAMING_ERR_EN
        ,
        .framing_err  (framing_err)
`endif
    );

    uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx32),
        .s_tick       (s_tick),
        .dout         (dout32),
        .rx_done_tick (done32)
`ifdef UART_RX_FRAMING_ERR_EN
        ,
        .framing_err  (ferr32)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx32 = v;
        else     rx   = v;
    endtask

    // Stop-low frames release the line 3/4 through the stop bit so the tail cannot pass the start check.
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit stop_low);
        if (!sel) begin
            sb_q.push_back(exp_t'{data, stop_low});
            pushes++;
        end
        set_line(sel, 1'b0);
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, data[i]);
            wait_clk(BIT_CLK);
        end
        if (stop_low) begin
            set_line(sel, 1'b0);
            wait_clk(BIT_CLK * 3 / 4);
            set_line(sel, 1'b1);
            wait_clk(BIT_CLK / 4);
        end else begin
            set_line(sel, 1'b1);
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
    endtask

    // s_tick: one clk high every 4 clk, changed just after the rising edge.
    initial begin
        int cnt = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            s_tick = (cnt == 3);
            cnt    = (cnt + 1) % 4;
        end
    end

    // Scoreboard consumer for the default-parameter instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                pulses++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", rx_done_tick, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("dout", dout, e.data);
`ifdef UART_RX_FRAMING_ERR_EN
                    check("framing_err", framing_err, e.ferr);
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   p0;
        int   cnt;
        bit   found;

        vecs[0] = '{8'hA5, 1'b0, BIT_CLK,     8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 0,           8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, BIT_CLK,     8'hFF, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 2 * BIT_CLK, 8'h5A, 1'b1};
        vecs[4] = '{8'h01, 1'b0, BIT_CLK,     8'h01, 1'b0};
        vecs[5] = '{8'h80, 1'b0, BIT_CLK,     8'h80, 1'b0};

        reset = 1'b1;
        rx    = 1'b1;
        rx32  = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_done", rx_done_tick, 1'b0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_sync_meta", dut.u_rx_sync.meta, 1'b1);
        check("rst_sync_q", dut.u_rx_sync.q, 1'b1);
        wait_clk(1);
        reset = 1'b0;
        wait_clk(BIT_CLK);

        // Table of frames; a zero gap makes the next start follow the stop bit directly.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(exp_t'{vecs[i].exp_dout, vecs[i].exp_ferr});
            pushes++;
            set_line(1'b0, 1'b0);
            wait_clk(BIT_CLK);
            for (int k = 0; k < 8; k++) begin
                set_line(1'b0, vecs[i].data[k]);
                wait_clk(BIT_CLK);
            end
            set_line(1'b0, vecs[i].stop_low ? 1'b0 : 1'b1);
            wait_clk(vecs[i].stop_low ? BIT_CLK * 3 / 4 : BIT_CLK);
            set_line(1'b0, 1'b1);
            if (vecs[i].stop_low) wait_clk(BIT_CLK / 4);
            wait_clk(vecs[i].gap);
        end
        wait_drain("table_drain", 4 * BIT_CLK);

        // Start-bit glitch of 3 tick periods.
        p0 = pulses;
        rx = 1'b0;
        wait_clk(12);
        rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        @(negedge clk);
        check("glitch_no_pulse", pulses, p0);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        send_frame(1'b0, 8'h3C, 1'b0);
        wait_drain("glitch_next_frame", 4 * BIT_CLK);

        // One-clk reset in the middle of data bit 4 of 0x81.
        p0 = pulses;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int k = 0; k < 4; k++) begin
            rx = (8'h81 >> k) & 8'h01;
            wait_clk(BIT_CLK);
        end
        rx = 1'b0;
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        rx    = 1'b1;
        wait_clk(4 * BIT_CLK);
        @(negedge clk);
        check("rst_mid_no_pulse", pulses, p0);
        check("rst_mid_dout", dout, 8'h00);
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        send_frame(1'b0, 8'hC3, 1'b0);
        wait_drain("rst_mid_next_frame", 4 * BIT_CLK);

        // SB_TICK=32: count ticks from the last data-bit sample to rx_done_tick.
        cnt   = 0;
        found = 1'b0;
        fork
            send_frame(1'b1, 8'h7E, 1'b0);
            begin
                for (int i = 0; i < 20 * BIT_CLK && !found; i++) begin
                    @(negedge clk);
                    if (dut32.state_q == DATA && dut32.n_q == 3'd7 && dut32.s_q == 5'd15 && s_tick)
                        found = 1'b1;
                end
                check("sb32_last_sample_seen", found, 1'b1);
                if (found) begin
                    for (int i = 0; i < 4 * BIT_CLK; i++) begin
                        @(negedge clk);
                        if (s_tick) cnt++;
                        if (done32) break;
                    end
                    check("sb32_done_seen", done32, 1'b1);
                    check("sb32_tick_gap", cnt, 32);
                    check("sb32_dout", dout32, 8'h7E);
                end
            end
        join
        wait_clk(2 * BIT_CLK);

        check("pulse_total", pulses, pushes);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
